alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one MiniAlu-class arithmetic unit (ADD/SUB/iterative MUL) between two requesters.
// - Round-robin arbitration, a per-requester req/done handshake and a multi-cycle shift-add multiplier.
// - Sits between the instruction decode stage and a second requester (e.g. a LED/IO sequencer).
// - Serialises all arithmetic through a single datapath.
// PARAMETERS
// - DATA_WIDTH  8  operand width; result width is 2*DATA_WIDTH; MUL takes DATA_WIDTH EXEC cycles
// PORTS
// - Clock    in   1             single clock, rising edge
// - Reset    in   1             asynchronous, active-high; clears all state
// - iReq     in   2             iReq[n]=1 -> requester n requests an op; operands held stable until oDone[n]
// - iOp0     in   2             requester 0 opcode: 00 ADD, 01 SUB, 10 MUL, 11 reserved
// - iOpA0    in   DATA_WIDTH    requester 0 operand A
// - iOpB0    in   DATA_WIDTH    requester 0 operand B
// - iOp1     in   2             requester 1 opcode (same encoding)
// - iOpA1    in   DATA_WIDTH    requester 1 operand A
// - iOpB1    in   DATA_WIDTH    requester 1 operand B
// - oGrant   out  2             one-hot owner of the ALU; high from EXEC entry through DONE
// - oDone    out  2             oDone[n] pulses 1 cycle when requester n's result is valid
// - oResult  out  2*DATA_WIDTH  result of the most recent completed op; held until the next DONE
// - oBusy    out  1             1 while in EXEC or DONE
// BEHAVIOUR
// - Reset:
//   - oGrant=0, oDone=0, oResult=0, oBusy=0, state=IDLE, last-served pointer=1 (requester 0 wins first tie).
// - FSM states: IDLE, EXEC, DONE.
// - IDLE:
//   - Stay in IDLE if iReq==0.
//   - Otherwise pick the winner: the single requester if only one; if both, the one NOT equal to the last-served pointer.
//   - On that edge: latch the winner's op and operands, set oGrant, set the pointer to the winner, go to EXEC.
// - EXEC, ADD: one cycle; result = zext(A)+zext(B) mod 2^(2W) -> DONE.
// - EXEC, SUB: one cycle; result = zext(A)-zext(B) mod 2^(2W) (3-5 = 16'hFFFE at W=8) -> DONE.
// - EXEC, MUL: unsigned shift-add, one multiplier bit per cycle, LSB first, exactly DATA_WIDTH cycles -> DONE.
// - EXEC, op 11: one cycle, result = 0 -> DONE.
// - DONE: oResult updated, oDone[owner]=1 for exactly this cycle, oGrant still set; next state IDLE, unconditionally.
// - Latency, counted from the edge that samples iReq in IDLE:
//   - ADD/SUB/11: oDone high after edge +2.
//   - MUL: oDone high after edge +1+DATA_WIDTH.
//   - Minimum spacing between consecutive grants: 3 cycles.
// - Requester rule: drop iReq[n] in the cycle after oDone[n].
//   - If iReq[n] is still high when the FSM is back in IDLE, it counts as a new request.
//   - Round-robin still yields to the other requester if both are pending.
// - iReq drop during EXEC: the op completes, DONE still pulses and oResult still updates; no abort path.
// - Operand changes after grant are ignored; only latched copies are used.
// - Reset mid-operation: the in-flight op is discarded and no oDone is issued; outputs take reset values asynchronously.
// - oResult is never cleared except by Reset.
// - oDone is never high for both requesters at once.
// - oGrant is zero in IDLE.
// TESTING
// - Reset, then iReq=01, ADD 8'hFF+8'h01 -> oGrant=01; oDone=01 two edges later; oResult=16'h0100; oBusy low after.
// - iReq=10, MUL 8'hFF*8'hFF -> oDone=10 after 9 edges; oResult=16'hFE01; oGrant=10 for all 9 cycles.
// - iReq=11 held continuously with ADD ops -> grants alternate 01,10,01,10 (first 01 after reset); no starvation.
// - Requester 0 SUB 3-5, iReq[0] dropped during EXEC -> oDone[0] still pulses; oResult=16'hFFFE.
// - Reset asserted mid-MUL (4th EXEC cycle) -> all outputs 0 immediately, no oDone; next request after release served normally.
// - Requester 1 op 11 with operands 8'hAA,8'h55 -> oResult=0 after 2 edges; prior oResult held in between.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin arbiter around one ADD/SUB/shift-add MUL datapath
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [1:0]                iReq,
   input  logic [1:0]                iOp0,
   input  logic [DATA_WIDTH-1:0]     iOpA0,
   input  logic [DATA_WIDTH-1:0]     iOpB0,
   input  logic [1:0]                iOp1,
   input  logic [DATA_WIDTH-1:0]     iOpA1,
   input  logic [DATA_WIDTH-1:0]     iOpB1,
   output logic [1:0]                oGrant,
   output logic [1:0]                oDone,
   output logic [2*DATA_WIDTH-1:0]   oResult,
   output logic                      oBusy
);
   localparam int RW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t                state;
   logic                  owner;
   logic                  last;
   logic [1:0]            op;
   logic [RW-1:0]         mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [RW-1:0]         acc;
   logic [CW-1:0]         cnt;

   logic                  winner;
   logic [1:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_a;
   logic [DATA_WIDTH-1:0] sel_b;
   logic [RW-1:0]         acc_next;
   logic [RW-1:0]         exec_result;
   logic                  exec_last;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      winner = (iReq == 2'b11) ? ~last : iReq[1];
      sel_op = winner ? iOp1  : iOp0;
      sel_a  = winner ? iOpA1 : iOpA0;
      sel_b  = winner ? iOpB1 : iOpB0;
   end

   // mcand holds zero-extended A and mplier holds B, so ADD/SUB reuse the MUL registers.
   always_comb begin
      acc_next  = acc + (mplier[0] ? mcand : '0);
      exec_last = (op != 2'b10) || (cnt == CW'(DATA_WIDTH - 1));
      case (op)
         2'b00:   exec_result = mcand + {{DATA_WIDTH{1'b0}}, mplier};
         2'b01:   exec_result = mcand - {{DATA_WIDTH{1'b0}}, mplier};
         2'b10:   exec_result = acc_next;
         default: exec_result = '0;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         owner   <= 1'b0;
         last    <= 1'b1;
         op      <= 2'b00;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         oGrant  <= 2'b00;
         oDone   <= 2'b00;
         oResult <= '0;
         oBusy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               oDone <= 2'b00;
               if (iReq != 2'b00) begin
                  owner  <= winner;
                  last   <= winner;
                  op     <= sel_op;
                  mcand  <= {{DATA_WIDTH{1'b0}}, sel_a};
                  mplier <= sel_b;
                  acc    <= '0;
                  cnt    <= '0;
                  oGrant <= winner ? 2'b10 : 2'b01;
                  oBusy  <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (exec_last) begin
                  oResult <= exec_result;
                  oDone   <= owner ? 2'b10 : 2'b01;
                  state   <= DONE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
               end
            end
            DONE: begin
               oDone  <= 2'b00;
               oGrant <= 2'b00;
               oBusy  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench with a transaction-level model checked every cycle
module tb_alu_share_arbiter;
   localparam int W = 8;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic [1:0]    iReq = 2'b00;
   logic [1:0]    iOp0 = 2'b00, iOp1 = 2'b00;
   logic [W-1:0]  iOpA0 = '0, iOpB0 = '0, iOpA1 = '0, iOpB1 = '0;
   logic [1:0]    oGrant, oDone;
   logic [2*W-1:0] oResult;
   logic          oBusy;

   int total = 0;
   int passed = 0;

   alu_share_arbiter #(.DATA_WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset), .iReq(iReq),
      .iOp0(iOp0), .iOpA0(iOpA0), .iOpB0(iOpB0),
      .iOp1(iOp1), .iOpA1(iOpA1), .iOpB1(iOpB1),
      .oGrant(oGrant), .oDone(oDone), .oResult(oResult), .oBusy(oBusy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   // Model: an accepted op occupies the unit for (exec cycles + 1 done cycle); result is plain arithmetic.
   int          m_cnt;
   logic        m_owner, m_last;
   logic [15:0] m_res, m_pend;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_cnt = 0; m_last = 1'b1; m_owner = 1'b0; m_res = '0; m_pend = '0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 1) m_res = m_pend;
      end else if (iReq != 2'b00) begin
         logic [1:0]  op;
         logic [15:0] a, b;
         m_owner = (iReq == 2'b11) ? !m_last : iReq[1];
         m_last  = m_owner;
         op = m_owner ? iOp1 : iOp0;
         a  = {8'h00, (m_owner ? iOpA1 : iOpA0)};
         b  = {8'h00, (m_owner ? iOpB1 : iOpB0)};
         case (op)
            2'd0: m_pend = a + b;
            2'd1: m_pend = a - b;
            2'd2: m_pend = a * b;
            default: m_pend = 16'h0000;
         endcase
         m_cnt = (op == 2'd2) ? W + 1 : 2;
      end
   end

   always @(negedge Clock) begin
      if (!Reset) begin
         logic [1:0] eg;
         eg = (m_cnt > 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
         check("model_grant", {30'd0, oGrant}, {30'd0, eg});
         check("model_done", {30'd0, oDone}, {30'd0, (m_cnt == 1) ? eg : 2'b00});
         check("model_result", {16'd0, oResult}, {16'd0, m_res});
         check("model_busy", {31'd0, oBusy}, {31'd0, m_cnt > 0});
      end
   end

   task automatic run_op(input int n, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit drop_early, output int edges, output logic [15:0] res);
      logic [15:0] prev;
      @(negedge Clock);
      prev = oResult;
      if (n == 0) begin iOp0 = op; iOpA0 = a; iOpB0 = b; end
      else        begin iOp1 = op; iOpA1 = a; iOpB1 = b; end
      iReq[n] = 1'b1;
      edges = 0;
      while (1) begin
         @(posedge Clock);
         edges++;
         @(negedge Clock);
         if (edges == 1) begin
            check("grant_onehot", {30'd0, oGrant}, (n == 0) ? 32'd1 : 32'd2);
            if (drop_early) iReq[n] = 1'b0;
         end
         if (oDone[n]) break;
         check("result_held", {16'd0, oResult}, {16'd0, prev});
         if (edges >= 40) begin
            check("done_timeout", 32'd0, 32'd1);
            break;
         end
      end
      iReq[n] = 1'b0;
      res = oResult;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1;
      iReq  = 2'b00;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      int          edges;
      logic [15:0] res;
      logic [1:0]  seq[$];
      logic [1:0]  prev_g;

      repeat (2) @(negedge Clock);
      check("reset_grant", {30'd0, oGrant}, 32'd0);
      check("reset_done", {30'd0, oDone}, 32'd0);
      check("reset_result", {16'd0, oResult}, 32'd0);
      check("reset_busy", {31'd0, oBusy}, 32'd0);
      Reset = 1'b0;

      run_op(0, 2'b00, 8'hFF, 8'h01, 1'b0, edges, res);
      check("add_edges", edges, 32'd2);
      check("add_result", {16'd0, res}, 32'h0100);
      @(negedge Clock);
      check("add_busy_after", {31'd0, oBusy}, 32'd0);

      run_op(1, 2'b10, 8'hFF, 8'hFF, 1'b0, edges, res);
      check("mul_edges", edges, 32'd9);
      check("mul_result", {16'd0, res}, 32'hFE01);

      run_op(1, 2'b10, 8'h0D, 8'h0B, 1'b0, edges, res);
      check("mul2_result", {16'd0, res}, 32'h008F);

      do_reset();
      iOp0 = 2'b00; iOpA0 = 8'h01; iOpB0 = 8'h02;
      iOp1 = 2'b00; iOpA1 = 8'h03; iOpB1 = 8'h04;
      iReq = 2'b11;
      prev_g = 2'b00;
      for (int i = 0; i < 40 && seq.size() < 4; i++) begin
         @(negedge Clock);
         if (oGrant != 2'b00 && prev_g == 2'b00) seq.push_back(oGrant);
         prev_g = oGrant;
      end
      iReq = 2'b00;
      check("rr_count", seq.size(), 32'd4);
      while (seq.size() < 4) seq.push_back(2'b00);
      check("rr_g0", {30'd0, seq[0]}, 32'd1);
      check("rr_g1", {30'd0, seq[1]}, 32'd2);
      check("rr_g2", {30'd0, seq[2]}, 32'd1);
      check("rr_g3", {30'd0, seq[3]}, 32'd2);
      for (int i = 0; i < 20 && oBusy; i++) @(negedge Clock);

      run_op(0, 2'b01, 8'd3, 8'd5, 1'b1, edges, res);
      check("sub_drop_edges", edges, 32'd2);
      check("sub_result", {16'd0, res}, 32'hFFFE);

      @(negedge Clock);
      iOp1 = 2'b10; iOpA1 = 8'h12; iOpB1 = 8'h34; iReq[1] = 1'b1;
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      check("midmul_busy", {31'd0, oBusy}, 32'd1);
      Reset = 1'b1;
      iReq  = 2'b00;
      #1;
      check("rst_async_grant", {30'd0, oGrant}, 32'd0);
      check("rst_async_done", {30'd0, oDone}, 32'd0);
      check("rst_async_result", {16'd0, oResult}, 32'd0);
      check("rst_async_busy", {31'd0, oBusy}, 32'd0);
      @(posedge Clock);
      @(negedge Clock);
      check("rst_no_done", {30'd0, oDone}, 32'd0);
      Reset = 1'b0;

      run_op(1, 2'b00, 8'd2, 8'd3, 1'b0, edges, res);
      check("post_rst_edges", edges, 32'd2);
      check("post_rst_result", {16'd0, res}, 32'h0005);

      run_op(0, 2'b00, 8'h10, 8'h20, 1'b0, edges, res);
      check("pre_rsv_result", {16'd0, res}, 32'h0030);
      run_op(1, 2'b11, 8'hAA, 8'h55, 1'b0, edges, res);
      check("rsv_edges", edges, 32'd2);
      check("rsv_result", {16'd0, res}, 32'h0000);

      repeat (3) @(negedge Clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
